// File: rtl/dense_pkg.sv
// Shared types and lane geometry for the dense_mult result path.
// Lane l carries diagonal d = l-(N-1); its beats walk down that diagonal.
package dense_pkg;

  localparam int N_DEF     = 3;
  localparam int OUT_W_DEF = 16;

  typedef logic [OUT_W_DEF-1:0] result_t;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_e;

  function automatic int lane_len(input int l, input int n);
    int d;
    d = l - (n - 1);
    return (d < 0) ? (n + d) : (n - d);
  endfunction

  function automatic int lane_row0(input int l, input int n);
    int d;
    d = l - (n - 1);
    return (d < 0) ? -d : 0;
  endfunction

  function automatic int lane_col0(input int l, input int n);
    int d;
    d = l - (n - 1);
    return (d > 0) ? d : 0;
  endfunction

endpackage

// File: rtl/dense_result_collector_drain.sv
// Row-major drain sequencer: registered valid/row/col/last held while the
// consumer stalls; last_hs marks the accepted (N-1,N-1) element.
module result_drain_ctrl
  import dense_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [IDX_W-1:0] m_row,
  output logic [IDX_W-1:0] m_col,
  output logic             m_last,
  output logic             last_hs
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic             valid_q, valid_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic             last_q, last_d;
  logic             hs;

  always_comb begin
    hs      = valid_q && m_ready;
    last_hs = hs && last_q;
    valid_d = valid_q;
    row_d   = row_q;
    col_d   = col_q;
    if (start) begin
      valid_d = 1'b1;
      row_d   = '0;
      col_d   = '0;
    end else if (hs) begin
      if (last_q) begin
        valid_d = 1'b0;
        row_d   = '0;
        col_d   = '0;
      end else if (col_q == LAST) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    // m_last is precomputed so it lines up with the registered index
    last_d = valid_d && (row_d == LAST) && (col_d == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      row_q   <= row_d;
      col_q   <= col_d;
      last_q  <= last_d;
    end
  end

  assign m_valid = valid_q;
  assign m_row   = row_q;
  assign m_col   = col_q;
  assign m_last  = last_q;

endmodule

// File: rtl/dense_result_collector.sv
// Captures the 2N-1 diagonal result lanes into an NxN buffer, then drains it
// row-major over valid/ready; extra or late beats are dropped and flagged.
module dense_result_collector
  import dense_pkg::*;
#(
  parameter int N            = N_DEF,
  parameter int OUTPUT_WIDTH = OUT_W_DEF,
  parameter int IDX_W        = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OUTPUT_WIDTH-1:0] s_in_bus [0:2*N-2],
  input  logic [0:2*N-2]          valid_bit_s_in,
  output logic [OUTPUT_WIDTH-1:0] m_data,
  output logic [IDX_W-1:0]        m_row,
  output logic [IDX_W-1:0]        m_col,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    err_overrun
);

  localparam int LANES  = 2 * N - 1;
  localparam int CELLS  = N * N;
  localparam int CNT_W  = IDX_W + 1;
  localparam int CAP_W  = $clog2(CELLS + 1);
  localparam int CELL_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q [LANES];
  logic [CNT_W-1:0]        cnt_d [LANES];
  logic [CAP_W-1:0]        captured_q, captured_d;
  logic                    err_q, err_d;
  logic [0:LANES-1]        wr_en;
  logic [CAP_W-1:0]        n_wr;
  logic                    ovr_any;
  logic                    drain_start;
  logic [OUTPUT_WIDTH-1:0] mem_q [CELLS];
  logic [CELL_W-1:0]       rd_idx;

  always_comb begin
    wr_en   = '0;
    n_wr    = '0;
    ovr_any = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      wr_en[i] = (state_q == COLLECT) && valid_bit_s_in[i]
               && (cnt_q[i] < CNT_W'(lane_len(i, N)));
      ovr_any  = ovr_any | (valid_bit_s_in[i] & ~wr_en[i]);
      n_wr     = n_wr + CAP_W'(wr_en[i]);
      cnt_d[i] = frame_done ? '0 : cnt_q[i] + CNT_W'(wr_en[i]);
    end
    captured_d  = frame_done ? '0 : captured_q + n_wr;
    err_d       = err_q | ovr_any;
    state_d     = state_q;
    drain_start = 1'b0;
    case (state_q)
      COLLECT: begin
        // Writes landing on this edge count, so DRAIN follows the last beat directly
        if (captured_d == CAP_W'(CELLS)) begin
          state_d     = DRAIN;
          drain_start = 1'b1;
        end
      end
      DRAIN:   if (frame_done) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= COLLECT;
      captured_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < LANES; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      captured_q <= captured_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Each (lane, beat) pair owns exactly one buffer cell, so writes never collide
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar k = 0; k < lane_len(l, N); k++) begin : g_beat
      localparam int CELL = (lane_row0(l, N) + k) * N + lane_col0(l, N) + k;
      always_ff @(posedge clk) begin
        if (wr_en[l] && (cnt_q[l] == CNT_W'(k))) mem_q[CELL] <= s_in_bus[l];
      end
    end
  end

  result_drain_ctrl #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_drain (
    .clk     (clk),
    .rst     (rst),
    .start   (drain_start),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_row   (m_row),
    .m_col   (m_col),
    .m_last  (m_last),
    .last_hs (frame_done)
  );

  always_comb begin
    rd_idx = CELL_W'(m_row) * CELL_W'(N) + CELL_W'(m_col);
    m_data = '0;
    if (m_valid) m_data = mem_q[rd_idx];
  end

  assign busy        = (state_q == DRAIN);
  assign err_overrun = err_q;

endmodule

// File: tb/tb_dense_result_collector.sv
// Self-checking bench: random/directed lane traffic against a queue-based
// matrix model, checked every negedge.
module tb_dense_result_collector;

  localparam int N     = 3;
  localparam int W     = 16;
  localparam int IW    = 2;
  localparam int LANES = 2 * N - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  s_in_bus [0:LANES-1];
  logic [0:LANES-1] vld;
  logic [W-1:0]  m_data;
  logic [IW-1:0] m_row, m_col;
  logic          m_valid, m_ready, m_last, busy, frame_done, err_overrun;

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] exp_q[$];
  int           ei = 0;
  bit           exp_err = 1'b0;
  int           hs_cnt = 0;
  int           fd_cnt = 0;
  logic [W-1:0] got [N*N];

  always #5 clk = ~clk;

  dense_result_collector #(.N(N), .OUTPUT_WIDTH(W), .IDX_W(IW)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_in_bus       (s_in_bus),
    .valid_bit_s_in (vld),
    .m_data         (m_data),
    .m_row          (m_row),
    .m_col          (m_col),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_last         (m_last),
    .busy           (busy),
    .frame_done     (frame_done),
    .err_overrun    (err_overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int llen(input int l);
    return N - ((l > N - 1) ? (l - (N - 1)) : ((N - 1) - l));
  endfunction

  // Model: a completed frame is a row-major queue; outputs valid iff it is non-empty.
  always @(negedge clk) begin
    bit ev;
    int i0;
    if (!rst) begin
      ev = (exp_q.size() != 0);
      i0 = ei;
      chk("m_valid", m_valid, ev);
      chk("busy", busy, ev);
      chk("err_overrun", err_overrun, exp_err);
      chk("frame_done", frame_done, ev && m_ready && (i0 == N * N - 1));
      if (ev) begin
        chk("m_data", m_data, exp_q[0]);
        chk("m_row", m_row, i0 / N);
        chk("m_col", m_col, i0 % N);
        chk("m_last", m_last, i0 == N * N - 1);
        if (m_ready) begin
          got[i0] = m_data;
          void'(exp_q.pop_front());
          ei = (i0 == N * N - 1) ? 0 : i0 + 1;
          hs_cnt++;
        end
      end else begin
        chk("m_last_idle", m_last, 0);
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic pulse(input int l, input logic [W-1:0] v);
    for (int i = 0; i < LANES; i++) s_in_bus[i] = W'($urandom);
    vld    = '0;
    vld[l] = 1'b1;
    s_in_bus[l] = v;
    @(posedge clk); #1;
    vld = '0;
  endtask

  // mode 1: every unfinished lane valid each cycle; mode 0: random gaps.
  task automatic run_frame(input int mode, input bit seq, input bit ovr);
    logic [W-1:0] mat [N*N];
    int pos [LANES];
    bit injd, inj, full_last, done;
    int d, r, c;
    for (int i = 0; i < N * N; i++) mat[i] = seq ? W'(i + 1) : W'($urandom);
    for (int l = 0; l < LANES; l++) pos[l] = 0;
    injd = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      full_last = (pos[LANES-1] >= llen(LANES - 1));
      inj = 1'b0;
      for (int l = 0; l < LANES; l++) begin
        s_in_bus[l] = W'($urandom);
        vld[l] = 1'b0;
        if (pos[l] < llen(l) && (mode == 1 || $urandom_range(1, 0) == 1)) begin
          d = l - (N - 1);
          r = pos[l] + ((d < 0) ? -d : 0);
          c = pos[l] + ((d > 0) ? d : 0);
          s_in_bus[l] = mat[r * N + c];
          vld[l] = 1'b1;
          pos[l]++;
        end
      end
      if (ovr && full_last && !injd) begin
        vld[LANES-1] = 1'b1;
        s_in_bus[LANES-1] = 16'hDEAD;
        inj  = 1'b1;
        injd = 1'b1;
      end
      @(posedge clk); #1;
      vld = '0;
      if (inj) exp_err = 1'b1;
      done = 1'b1;
      for (int l = 0; l < LANES; l++) if (pos[l] < llen(l)) done = 1'b0;
      if (done) begin
        for (int i = 0; i < N * N; i++) exp_q.push_back(mat[i]);
        chk("drain_latency", m_valid, 1);
        return;
      end
    end
    chk("capture_timeout", 0, 1);
  endtask

  // rmode 0: ready high; 1: pattern 1,0,0; 2: random.
  task automatic drain(input int rmode);
    for (int cyc = 0; cyc < 400; cyc++) begin
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 3 == 0);
        default: m_ready = $urandom_range(1, 0);
      endcase
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        chk("collect_after_done", busy, 0);
        return;
      end
    end
    chk("drain_timeout", 0, 1);
    exp_q.delete();
    ei = 0;
  endtask

  initial begin
    int base;
    vld = '0;
    m_ready = 1'b0;
    for (int i = 0; i < LANES; i++) s_in_bus[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_row", m_row, 0);
    chk("rst_m_col", m_col, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err", err_overrun, 0);
    rst = 1'b0;

    // Directed lane pulses with hand-mapped expectations
    pulse(0, 0);  pulse(1, 10); pulse(2, 20); pulse(3, 30); pulse(4, 40);
    pulse(2, 21); pulse(2, 22); pulse(1, 11); pulse(3, 31);
    exp_q = '{16'd20, 16'd30, 16'd40, 16'd10, 16'd21, 16'd31, 16'd0, 16'd11, 16'd22};
    chk("t1_latency", m_valid, 1);
    drain(0);
    chk("t1_c00", got[0], 20);
    chk("t1_c11", got[4], 21);
    chk("t1_c22", got[8], 22);
    chk("t1_c20", got[6], 0);
    chk("t1_c02", got[2], 40);
    chk("t1_c21", got[7], 11);
    chk("t1_fd_once", fd_cnt, 1);

    // All lanes together, C[i][j] = 3i+j+1
    run_frame(1, 1'b1, 1'b0);
    drain(0);
    for (int i = 0; i < N * N; i++) chk("t2_seq", got[i], i + 1);

    // Stall pattern during drain
    run_frame(0, 1'b0, 1'b0);
    drain(1);

    // Back-to-back frames
    run_frame(0, 1'b0, 1'b0);
    drain(0);
    run_frame(1, 1'b0, 1'b0);
    drain(2);

    // Overrun on the length-1 lane; sticky through the following frame
    run_frame(1, 1'b0, 1'b1);
    drain(0);
    run_frame(0, 1'b0, 1'b0);
    drain(2);
    chk("t4_sticky", err_overrun, 1);

    // Reset mid-drain after four handshakes
    run_frame(1, 1'b0, 1'b0);
    base = hs_cnt;
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 50 && (hs_cnt - base) < 4; cyc++) begin
      @(posedge clk); #1;
    end
    chk("t5_hs4", hs_cnt - base, 4);
    rst = 1'b1;
    exp_q.delete();
    ei = 0;
    exp_err = 1'b0;
    #1;
    chk("t5_m_valid", m_valid, 0);
    chk("t5_m_data", m_data, 0);
    chk("t5_m_row", m_row, 0);
    chk("t5_m_col", m_col, 0);
    chk("t5_m_last", m_last, 0);
    chk("t5_busy", busy, 0);
    chk("t5_err", err_overrun, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(1, 1'b1, 1'b0);
    drain(0);
    chk("t5_fresh_c00", got[0], 1);
    chk("t5_fresh_c22", got[8], 9);

    for (int f = 0; f < 6; f++) begin
      run_frame(int'($urandom_range(1, 0)), 1'b0, 1'b0);
      drain(2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
